task_dispatcher: RTL
====================

# task_dispatcher

Parametrised successor of the GPU task scheduler: walks a task program held in task memory, decodes each 3-word task header, waits until the cores selected by the task's mask are free (with optional ordering and barrier constraints), then streams the task payload to those cores over a shared word bus with valid/ready backpressure. It sits between the task memory and the core array. Core count, word width, frame size and address depth are parameters.

## Interface
- ADDR_W, 10, task memory address width (depth 2^ADDR_W words)
- WORD_W, 16, memory/bus word width
- CORE_NUM, 16, number of cores; 1..WORD_W
- FRAME_WORDS, 64, words per frame; power of two, ≥4
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- prog_loading  in  1  1 = program being written; dispatcher held idle at address 0
- core_ready  in  CORE_NUM  per-core idle flag
- mem_rd_en  out  1  task memory read strobe
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  WORD_W  read data, valid one cycle after mem_rd_en
- out_valid  out  1  payload word valid
- out_ready  in  1  core bus accepts word
- out_data  out  WORD_W  payload word
- out_mask  out  CORE_NUM  destination cores of current word
- out_first / out_last  out  1  first / last payload word of task
- frame_being_sent  out  1  high while in STREAM or DRAIN
- done  out  1  program finished (sticky until prog_loading=1)
- hdr_err  out  1  one-cycle pulse: header mask mismatch
- task_cnt  out  16  tasks fully dispatched since prog_loading fell

## Operation
- Header at base: w0[5:0] = frame_cnt (frames occupied, header included; 0 = end of program), w0[6] = ORDER, w0[7] = BARRIER, w0[15:8] ignored; w1[CORE_NUM-1:0] = mask; w2 = mask copy.
- Payload: words base+3 .. base+frame_cnt*FRAME_WORDS-1; next base = base + frame_cnt*FRAME_WORDS.
- Per-core pending bit: set for every mask core when out_last is accepted; cleared on any cycle core_ready[i]=0. Core free = core_ready[i] & ~pending[i].
- Launch condition: all mask cores free; ORDER additionally needs all cores of previous task's mask free; BARRIER needs all CORE_NUM cores free.
- States: IDLE → HDR0 → HDR1 → HDR2 → WAIT → STREAM → DRAIN → HDR0 …; DONE.
- IDLE: while prog_loading=1; base=0, done=0, task_cnt=0, pending=0. prog_loading=0 → HDR0.
- HDR0..HDR2 read the three header words in consecutive cycles.
- WAIT: frame_cnt=0 → DONE. w1≠w2 or mask=0 → hdr_err pulse, task skipped (base advances, no pending change). Else wait for launch condition.
- STREAM: one read per cycle while 2-entry skid buffer not full; out_data from buffer; no bubbles when out_ready=1. DRAIN empties buffer after last read; out_last on final word; on its acceptance task_cnt+1, pending set, → HDR0.
- Next-base carry out of ADDR_W → DONE after current task (no wrap).
- prog_loading=1 in any state: abort within one cycle, out_valid=0, pending cleared, partial task not counted, → IDLE.
- out_data/out_mask held stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_mask=0, out_first=0, out_last=0, frame_being_sent=0, done=0, hdr_err=0, task_cnt=0; state IDLE.
- prog_loading sampled 0 at cycle t: header reads at t+1, t+2, t+3; WAIT decision t+4; first payload read t+4 if free; out_valid/out_first t+5.
- Last accepted word to next header read: 1 cycle.
- Throughput 1 word/cycle with out_ready=1; pending set and core_ready=0 same cycle: set wins that cycle, cleared next.

## Test plan
- Task @0: 0x0001,0x000f,0x000f; @64: 0x0000 → 61 words to mask 0x000f, out_first at word 3 data, out_last at word 63, task_cnt=1, done=1.
- Mask collision: task A mask 0x00f0, task B mask 0x00f0; core_ready[7:4] held 1 → B waits; drop then raise core_ready[7:4] → B streams.
- BARRIER task 0x0081 with core_ready=0xfff0 → stalls; core_ready=0xffff → streams within 1 cycle.
- out_ready toggling 1-0-1 every cycle during 61-word task → all words delivered in order, none duplicated, data stable when stalled.
- w1=0x000f, w2=0x00f0 → hdr_err pulse, next task at base+64 fetched, task_cnt unchanged.
- prog_loading=1 mid-stream then reset_n=0 → out_valid low within 1 cycle; all outputs at reset values.

Source files
------------

// File: rtl/task_dispatcher.sv
// task_dispatcher: walks a task program in memory, decodes 3-word headers,
// waits for the selected cores to become free, then streams the payload to
// them through a 2-entry skid buffer with valid/ready backpressure.
module task_dispatcher #(
  parameter int ADDR_W      = 10,
  parameter int WORD_W      = 16,
  parameter int CORE_NUM    = 16,
  parameter int FRAME_WORDS = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                prog_loading,
  input  logic [CORE_NUM-1:0] core_ready,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [CORE_NUM-1:0] out_mask,
  output logic                out_first,
  output logic                out_last,
  output logic                frame_being_sent,
  output logic                done,
  output logic                hdr_err,
  output logic [15:0]         task_cnt
);

  localparam int FW_LOG2 = $clog2(FRAME_WORDS);
  // frame_cnt (6 bits) times frame size always fits in LEN_W bits
  localparam int LEN_W   = 6 + FW_LOG2;
  // base + task length computed without overflow so the carry can be seen
  localparam int EXT_W   = ADDR_W + LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_WAIT, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0]   base_reg, rd_addr_reg;
  logic [5:0]          frame_cnt_reg;
  logic                order_reg, barrier_reg;
  logic [WORD_W-1:0]   w1_reg;
  logic [CORE_NUM-1:0] mask, free, prev_mask_reg, pending_reg, pending_next;
  logic                hdr_fresh_reg;
  logic [LEN_W-1:0]    task_len, payload_len, rd_left_reg, out_left_reg;
  logic                first_reg;
  logic [15:0]         task_cnt_reg;

  logic [WORD_W-1:0]   skid_mem [0:1];
  logic                wr_ptr_reg, rd_ptr_reg, inflight_reg;
  logic [1:0]          count_reg, occupancy;

  logic [EXT_W-1:0]    next_base_ext;
  logic                base_carry;
  logic                end_prog, hdr_bad, launch_ok, launch;
  logic                can_read, stream_rd, pop, last_acc, advance;
  logic                skid_wr, skid_rd;

  // ---------------- datapath decisions ----------------
  assign mask          = w1_reg[CORE_NUM-1:0];
  assign free          = core_ready & ~pending_reg;
  assign task_len      = {frame_cnt_reg, {FW_LOG2{1'b0}}};
  assign payload_len   = task_len - LEN_W'(3);
  assign next_base_ext = EXT_W'(base_reg) + EXT_W'(task_len);
  assign base_carry    = |next_base_ext[EXT_W-1:ADDR_W];

  // The mask copy (w2) is on mem_rdata only during the first WAIT cycle
  assign end_prog  = (state_reg == S_WAIT) && hdr_fresh_reg && (frame_cnt_reg == 6'd0);
  assign hdr_bad   = (state_reg == S_WAIT) && hdr_fresh_reg && (frame_cnt_reg != 6'd0) &&
                     ((mem_rdata != w1_reg) || (mask == '0)) && !prog_loading;
  assign launch_ok = ((mask & ~free) == '0) &&
                     (!order_reg || ((prev_mask_reg & ~free) == '0)) &&
                     (!barrier_reg || (&free));
  assign launch    = (state_reg == S_WAIT) && !end_prog && !hdr_bad && !prog_loading && launch_ok;

  // A read is issued only if its data is guaranteed a slot in the skid buffer
  assign occupancy = count_reg + {1'b0, inflight_reg};
  assign can_read  = occupancy < 2'd2;
  assign stream_rd = (state_reg == S_STREAM) && can_read && !prog_loading;
  assign pop       = out_valid && out_ready;
  assign last_acc  = pop && (out_left_reg == LEN_W'(1));
  assign advance   = hdr_bad || last_acc;
  assign skid_rd   = pop && (count_reg != 2'd0);
  // A word arriving into an empty buffer that is accepted at once bypasses it
  assign skid_wr   = inflight_reg && !((count_reg == 2'd0) && pop);

  // Per-core pending: a same-cycle set beats the clear from core_ready=0
  generate
    for (genvar gi = 0; gi < CORE_NUM; gi++) begin : g_pending
      assign pending_next[gi] = (last_acc && mask[gi]) ? 1'b1 :
                                (core_ready[gi] ? pending_reg[gi] : 1'b0);
    end
  endgenerate

  // ---------------- FSM ----------------
  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; program loading overrides everything
  always_comb begin
    state_next = state_reg;
    if (prog_loading) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: state_next = S_HDR0;
        S_HDR0: state_next = S_HDR1;
        S_HDR1: state_next = S_HDR2;
        S_HDR2: state_next = S_WAIT;
        S_WAIT: begin
          if (end_prog)    state_next = S_DONE;
          else if (hdr_bad) state_next = base_carry ? S_DONE : S_HDR0;
          else if (launch)  state_next = (payload_len == LEN_W'(1)) ? S_DRAIN : S_STREAM;
        end
        S_STREAM: if (stream_rd && (rd_left_reg == LEN_W'(1))) state_next = S_DRAIN;
        S_DRAIN:  if (last_acc) state_next = base_carry ? S_DONE : S_HDR0;
        S_DONE:   state_next = S_DONE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Memory read port and status outputs per state
  always_comb begin
    mem_rd_en        = 1'b0;
    mem_addr         = base_reg;
    frame_being_sent = 1'b0;
    done             = 1'b0;
    hdr_err          = hdr_bad;
    case (state_reg)
      S_HDR0: mem_rd_en = 1'b1;
      S_HDR1: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_reg + ADDR_W'(1);
      end
      S_HDR2: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_reg + ADDR_W'(2);
      end
      S_WAIT: if (launch) begin
        mem_rd_en = 1'b1;
        mem_addr  = base_reg + ADDR_W'(3);
      end
      S_STREAM: begin
        frame_being_sent = 1'b1;
        if (stream_rd) begin
          mem_rd_en = 1'b1;
          mem_addr  = rd_addr_reg;
        end
      end
      S_DRAIN: frame_being_sent = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- registers ----------------
  // Header capture, read/output counters, skid pointers and task bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_reg      <= '0;
      rd_addr_reg   <= '0;
      frame_cnt_reg <= '0;
      order_reg     <= 1'b0;
      barrier_reg   <= 1'b0;
      w1_reg        <= '0;
      prev_mask_reg <= '0;
      pending_reg   <= '0;
      hdr_fresh_reg <= 1'b0;
      rd_left_reg   <= '0;
      out_left_reg  <= '0;
      first_reg     <= 1'b0;
      task_cnt_reg  <= '0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      inflight_reg  <= 1'b0;
      count_reg     <= '0;
    end else if (prog_loading) begin
      base_reg      <= '0;
      prev_mask_reg <= '0;
      pending_reg   <= '0;
      hdr_fresh_reg <= 1'b0;
      rd_left_reg   <= '0;
      out_left_reg  <= '0;
      first_reg     <= 1'b0;
      task_cnt_reg  <= '0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      inflight_reg  <= 1'b0;
      count_reg     <= '0;
    end else begin
      pending_reg   <= pending_next;
      hdr_fresh_reg <= (state_reg == S_HDR2);
      if (state_reg == S_HDR1) begin
        frame_cnt_reg <= mem_rdata[5:0];
        order_reg     <= mem_rdata[6];
        barrier_reg   <= mem_rdata[7];
      end
      if (state_reg == S_HDR2) w1_reg <= mem_rdata;
      inflight_reg <= launch || stream_rd;
      if (launch) begin
        rd_addr_reg  <= base_reg + ADDR_W'(4);
        rd_left_reg  <= payload_len - LEN_W'(1);
        out_left_reg <= payload_len;
        first_reg    <= 1'b1;
      end else if (stream_rd) begin
        rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
        rd_left_reg <= rd_left_reg - LEN_W'(1);
      end
      if (pop) begin
        out_left_reg <= out_left_reg - LEN_W'(1);
        first_reg    <= 1'b0;
      end
      if (skid_wr) wr_ptr_reg <= ~wr_ptr_reg;
      if (skid_rd) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, skid_wr} - {1'b0, skid_rd};
      if (advance) base_reg <= next_base_ext[ADDR_W-1:0];
      if (last_acc) begin
        task_cnt_reg  <= task_cnt_reg + 16'd1;
        prev_mask_reg <= mask;
      end
    end
  end

  // Skid buffer storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (skid_wr) skid_mem[wr_ptr_reg] <= mem_rdata;
  end

  // Output word comes from the buffer head, or straight from memory when empty
  assign out_valid = ((count_reg != 2'd0) || inflight_reg) && !prog_loading;
  assign out_data  = !out_valid ? '0 :
                     ((count_reg != 2'd0) ? skid_mem[rd_ptr_reg] : mem_rdata);
  assign out_mask  = out_valid ? mask : '0;
  assign out_first = out_valid && first_reg;
  assign out_last  = out_valid && (out_left_reg == LEN_W'(1));
  assign task_cnt  = task_cnt_reg;

endmodule
